// File: rtl/spi_shifter.sv
// spi_shifter: SPI mode-0 slave byte shifter, MSB first, pins oversampled in the clk domain.
module spi_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ssn,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_overrun,
  output logic       busy,
  output logic       start,
  output logic       tx_byte_done
);
  logic [SYNC_STAGES-1:0] sck_q, ssn_q, mosi_q;
  logic                   sck_d, ssn_d;
  logic [7:0]             rx_sr, tx_sr, tx_buf;
  logic [2:0]             cnt;
  logic                   buf_full;
  logic                   sck_s, ssn_s, mosi_s, act;
  logic                   ssn_fall, ssn_rise, sck_rise, sck_fall;
  logic                   load, take, byte_end, store;
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ssn_s    = ssn_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign ssn_fall = ssn_d & ~ssn_s;
  assign ssn_rise = ~ssn_d & ssn_s;
  // sck edges only count once ssn has been low for at least one detected cycle
  assign act      = ~ssn_s & ~ssn_d;
  assign sck_rise = act & sck_s & ~sck_d;
  assign sck_fall = act & ~sck_s & sck_d;
  assign load     = ssn_fall | (sck_fall & (cnt == 3'd0));
  assign take     = load & buf_full;
  assign byte_end = sck_rise & (cnt == 3'd7);
  assign store    = tx_vld & (~buf_full | take);
  assign miso     = tx_sr[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q        <= '0;
      ssn_q        <= '1;
      mosi_q       <= '0;
      sck_d        <= 1'b0;
      ssn_d        <= 1'b1;
      rx_sr        <= '0;
      tx_sr        <= '0;
      tx_buf       <= '0;
      buf_full     <= 1'b0;
      cnt          <= '0;
      rx_dat       <= '0;
      rx_vld       <= 1'b0;
      tx_byte_done <= 1'b0;
      tx_overrun   <= 1'b0;
      busy         <= 1'b0;
      start        <= 1'b0;
    end else begin
      sck_q        <= {sck_q[SYNC_STAGES-2:0], sck};
      ssn_q        <= {ssn_q[SYNC_STAGES-2:0], ssn};
      mosi_q       <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d        <= sck_s;
      ssn_d        <= ssn_s;
      start        <= ssn_fall;
      busy         <= ~ssn_s;
      rx_vld       <= byte_end;
      tx_byte_done <= byte_end;
      tx_overrun   <= tx_vld & ~store;
      if (byte_end) rx_dat <= {rx_sr[6:0], mosi_s};
      cnt   <= (ssn_rise | ssn_fall) ? 3'd0 : sck_rise ? cnt + 3'd1 : cnt;
      rx_sr <= (ssn_rise | ssn_fall) ? 8'h00 : sck_rise ? {rx_sr[6:0], mosi_s} : rx_sr;
      tx_sr <= ssn_rise ? 8'h00 : load ? (buf_full ? tx_buf : 8'h00) :
               sck_fall ? {tx_sr[6:0], 1'b0} : tx_sr;
      if (store) tx_buf <= tx_dat;
      buf_full <= store | (buf_full & ~take);
    end
  end
endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: directed SPI master stimulus with hand-computed expectations.
module tb_spi_shifter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       sck = 1'b0, ssn = 1'b1, mosi = 1'b0;
  logic       miso, rx_vld, tx_overrun, busy, start, tx_byte_done;
  logic [7:0] rx_dat, tx_dat = 8'h00;
  logic       tx_vld = 1'b0;
  int         total = 0, bad = 0;
  int         rx_n = 0, start_n = 0, done_n = 0, ovr_n = 0;
  logic [7:0] rx_log [0:63];
  spi_shifter #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso),
    .rx_dat(rx_dat), .rx_vld(rx_vld), .tx_dat(tx_dat), .tx_vld(tx_vld),
    .tx_overrun(tx_overrun), .busy(busy), .start(start), .tx_byte_done(tx_byte_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_vld) begin
      if (rx_n < 64) rx_log[rx_n] = rx_dat;
      rx_n++;
    end
    if (start) start_n++;
    if (tx_byte_done) done_n++;
    if (tx_overrun) ovr_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] mo, input int nb, input bit echo,
                      input logic [7:0] ev, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = mo[i];
      repeat (8) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        tx_vld = 1'b0;
        if (echo && i == 0 && rx_vld) begin
          tx_dat = ev;
          tx_vld = 1'b1;
        end
      end
      tx_vld = 1'b0;
      sck = 1'b0;
    end
  endtask
  task automatic ssn_set(input logic v);
    ssn = v;
    repeat (8) @(negedge clk);
  endtask
  logic [7:0] mi;
  int r0, s0, d0, o0;
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_rx_dat", rx_dat, 0);
    chk("rst_rx_vld", rx_vld, 0);
    chk("rst_ovr", tx_overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_done", tx_byte_done, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_pulses", rx_n + start_n + done_n + ovr_n, 0);
    // five bytes in one frame, empty tx buffer
    r0 = rx_n; s0 = start_n; d0 = done_n;
    ssn_set(1'b0);
    chk("frame_busy", busy, 1);
    for (int b = 0; b < 5; b++) begin
      xfer(8'hAA + 8'(b), 8, 1'b0, 8'h00, mi);
      chk("frame_miso_zero", mi, 8'h00);
      chk("frame_busy_hold", busy, 1);
    end
    ssn_set(1'b1);
    chk("frame_busy_low", busy, 0);
    chk("frame_start_n", start_n - s0, 1);
    chk("frame_rx_n", rx_n - r0, 5);
    chk("frame_done_n", done_n - d0, 5);
    for (int b = 0; b < 5; b++) chk("frame_rx_dat", rx_log[r0 + b], 8'hAA + 8'(b));
    chk("rx_dat_hold", rx_dat, 8'hAE);
    // echo loop
    r0 = rx_n;
    ssn_set(1'b0);
    for (int b = 0; b < 5; b++) begin
      xfer(8'h10 + 8'(b), 8, b < 4, 8'(b), mi);
      chk("echo_miso", mi, (b == 0) ? 8'h00 : 8'(b - 1));
    end
    ssn_set(1'b1);
    chk("echo_rx_n", rx_n - r0, 5);
    for (int b = 0; b < 5; b++) chk("echo_rx_dat", rx_log[r0 + b], 8'h10 + 8'(b));
    // preload before ssn falls
    tx_dat = 8'h5A; tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (4) @(negedge clk);
    ssn_set(1'b0);
    xfer(8'hC3, 8, 1'b0, 8'h00, mi);
    chk("preload_first", mi, 8'h5A);
    xfer(8'h3C, 8, 1'b0, 8'h00, mi);
    chk("preload_second", mi, 8'h00);
    ssn_set(1'b1);
    // overrun
    o0 = ovr_n;
    tx_dat = 8'h11; tx_vld = 1'b1;
    @(negedge clk);
    tx_dat = 8'h22;
    @(negedge clk);
    chk("ovr_pulse", tx_overrun, 1);
    tx_vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_count", ovr_n - o0, 1);
    r0 = rx_n;
    ssn_set(1'b0);
    xfer(8'h33, 8, 1'b0, 8'h00, mi);
    ssn_set(1'b1);
    chk("ovr_kept_old", mi, 8'h11);
    chk("ovr_rx", rx_log[r0], 8'h33);
    // abort after 4 bits
    r0 = rx_n; d0 = done_n;
    ssn_set(1'b0);
    xfer(8'hF0, 4, 1'b0, 8'h00, mi);
    ssn_set(1'b1);
    chk("abort_rx_n", rx_n - r0, 0);
    chk("abort_done_n", done_n - d0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_miso", miso, 0);
    ssn_set(1'b0);
    xfer(8'h96, 8, 1'b0, 8'h00, mi);
    ssn_set(1'b1);
    chk("after_abort_rx_n", rx_n - r0, 1);
    chk("after_abort_rx", rx_log[r0], 8'h96);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
